// File: rtl/i2c_wr_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2c_wr_seq
//  Purpose  : Byte-level I2C write sequencer. For each accepted request it
//             sends START, {slave_address,W}, reg[15:8], reg[7:0], STOP,
//             paced at 4 strobes per SCL bit. Honours clock stretching and
//             re-sends a NACKed transaction up to MAX_RETRY times.
//  Ports    : clk, areset_n          clock / async active-low reset
//             strobe_100kHz          1-clk pacing strobe (only advance source)
//             enable                 request, word pending on register_address
//             slave_address[6:0]     7-bit device address
//             register_address[15:0] word to write, high byte first
//             register_done          1 strobe interval pulse, word finished
//             nack_err               sticky, word abandoned after retries
//             scl_t / sda_t          pad tristate (1 = release, 0 = drive low)
//             scl_i / sda_i          pad readback
//  Revision : 1.0  initial release
// ============================================================================
module i2c_wr_seq #(
  parameter int MAX_RETRY = 2
) (
  input  logic        clk,
  input  logic        areset_n,
  input  logic        strobe_100kHz,
  input  logic        enable,
  input  logic [6:0]  slave_address,
  input  logic [15:0] register_address,
  output logic        register_done,
  output logic        nack_err,
  output logic        scl_t,
  output logic        sda_t,
  input  logic        scl_i,
  input  logic        sda_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_SHIFT = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [2:0] c_max_retry = 3'(MAX_RETRY);

  // Pad readbacks are asynchronous to clk; two flops before use.
  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       w_scl_in;
  logic       w_sda_in;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_i};
      r_sda_sync <= {r_sda_sync[0], sda_i};
    end
  end

  assign w_scl_in = r_scl_sync[1];
  assign w_sda_in = r_sda_sync[1];

  state_t      r_state, w_state;
  logic [1:0]  r_phase, w_phase;
  logic [23:0] r_shreg, w_shreg;
  logic [23:0] r_word,  w_word;
  logic [2:0]  r_bit,   w_bit;
  logic [1:0]  r_byte,  w_byte;
  logic [2:0]  r_retry, w_retry;
  logic        r_retry_flag, w_retry_flag;
  logic        r_ack, w_ack;
  logic        w_scl_t, w_sda_t, w_done, w_nack_err;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state       <= S_IDLE;
      r_phase       <= 2'd0;
      r_shreg       <= 24'd0;
      r_word        <= 24'd0;
      r_bit         <= 3'd0;
      r_byte        <= 2'd0;
      r_retry       <= 3'd0;
      r_retry_flag  <= 1'b0;
      r_ack         <= 1'b0;
      scl_t         <= 1'b1;
      sda_t         <= 1'b1;
      register_done <= 1'b0;
      nack_err      <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_phase       <= w_phase;
      r_shreg       <= w_shreg;
      r_word        <= w_word;
      r_bit         <= w_bit;
      r_byte        <= w_byte;
      r_retry       <= w_retry;
      r_retry_flag  <= w_retry_flag;
      r_ack         <= w_ack;
      scl_t         <= w_scl_t;
      sda_t         <= w_sda_t;
      register_done <= w_done;
      nack_err      <= w_nack_err;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_phase      = r_phase;
    w_shreg      = r_shreg;
    w_word       = r_word;
    w_bit        = r_bit;
    w_byte       = r_byte;
    w_retry      = r_retry;
    w_retry_flag = r_retry_flag;
    w_ack        = r_ack;
    w_scl_t      = scl_t;
    w_sda_t      = sda_t;
    w_done       = register_done;
    w_nack_err   = nack_err;

    if (strobe_100kHz) begin
      case (r_state)
        S_IDLE: begin
          w_scl_t = 1'b1;
          w_sda_t = 1'b1;
          if (enable) begin
            w_word       = {slave_address, 1'b0, register_address};
            w_shreg      = {slave_address, 1'b0, register_address};
            w_bit        = 3'd0;
            w_byte       = 2'd0;
            w_retry_flag = 1'b0;
            w_phase      = 2'd0;
            w_state      = S_START;
          end
        end

        S_START: begin
          w_phase = r_phase + 2'd1;
          case (r_phase)
            2'd0, 2'd1: begin
              w_scl_t = 1'b1;
              w_sda_t = 1'b1;
            end
            2'd2:    w_sda_t = 1'b0;
            default: begin
              w_scl_t = 1'b0;
              w_state = S_SHIFT;
            end
          endcase
        end

        S_SHIFT: begin
          case (r_phase)
            2'd0: begin
              // sda_t is a release enable, so a '1' bit is sent by releasing.
              w_scl_t = 1'b0;
              w_sda_t = r_shreg[23];
              w_phase = 2'd1;
            end
            2'd1: begin
              w_scl_t = 1'b1;
              w_phase = 2'd2;
            end
            2'd2: begin
              // Slave stretching SCL: hold everything until it lets go.
              if (w_scl_in) w_phase = 2'd3;
            end
            default: begin
              w_scl_t = 1'b0;
              w_shreg = {r_shreg[22:0], 1'b0};
              w_phase = 2'd0;
              if (r_bit == 3'd7) begin
                w_bit   = 3'd0;
                w_state = S_ACK;
              end else begin
                w_bit = r_bit + 3'd1;
              end
            end
          endcase
        end

        S_ACK: begin
          case (r_phase)
            2'd0: begin
              w_scl_t = 1'b0;
              w_sda_t = 1'b1;
              w_phase = 2'd1;
            end
            2'd1: begin
              w_scl_t = 1'b1;
              w_phase = 2'd2;
            end
            2'd2: begin
              if (w_scl_in) begin
                w_ack   = ~w_sda_in;
                w_phase = 2'd3;
              end
            end
            default: begin
              w_scl_t = 1'b0;
              w_phase = 2'd0;
              if (r_ack) begin
                if (r_byte == 2'd2) begin
                  w_state = S_STOP;
                end else begin
                  w_byte  = r_byte + 2'd1;
                  w_state = S_SHIFT;
                end
              end else begin
                w_retry_flag = 1'b1;
                w_state      = S_STOP;
              end
            end
          endcase
        end

        S_STOP: begin
          case (r_phase)
            2'd0: begin
              w_scl_t = 1'b0;
              w_sda_t = 1'b0;
              w_phase = 2'd1;
            end
            2'd1: begin
              w_scl_t = 1'b1;
              w_phase = 2'd2;
            end
            2'd2: begin
              if (w_scl_in) w_phase = 2'd3;
            end
            default: begin
              w_sda_t = 1'b1;
              w_phase = 2'd0;
              if (r_retry_flag && (r_retry < c_max_retry)) begin
                // Replay the whole transaction from the latched word.
                w_retry      = r_retry + 3'd1;
                w_shreg      = r_word;
                w_bit        = 3'd0;
                w_byte       = 2'd0;
                w_retry_flag = 1'b0;
                w_state      = S_START;
              end else begin
                if (r_retry_flag) w_nack_err = 1'b1;
                w_done  = 1'b1;
                w_state = S_DONE;
              end
            end
          endcase
        end

        S_DONE: begin
          // Always passes through IDLE, so enable here is never accepted.
          w_done       = 1'b0;
          w_retry      = 3'd0;
          w_retry_flag = 1'b0;
          w_phase      = 2'd0;
          w_state      = S_IDLE;
        end

        default: begin
          w_scl_t = 1'b1;
          w_sda_t = 1'b1;
          w_phase = 2'd0;
          w_state = S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
